// File: rtl/slink_apb_tgt_pkt.sv
// APB target that tunnels each access as a request packet and completes it from the
// returned response packet. Define SLINK_APB_TGT_TIMEOUT_EN to enable the response timeout.
module slink_apb_tgt_pkt #(
    parameter logic [7:0] APB_READ_DT      = 8'h30,
    parameter logic [7:0] APB_READ_RSP_DT  = 8'h31,
    parameter logic [7:0] APB_WRITE_DT     = 8'h32,
    parameter logic [7:0] APB_WRITE_RSP_DT = 8'h33,
    parameter int         TIMEOUT_CYCLES   = 1024
) (
    input  logic        apb_clk,
    input  logic        apb_reset_n,
    input  logic        enable,
    input  logic        apb_psel,
    input  logic        apb_penable,
    input  logic        apb_pwrite,
    input  logic [31:0] apb_paddr,
    input  logic [31:0] apb_pwdata,
    output logic [31:0] apb_prdata,
    output logic        apb_pready,
    output logic        apb_pslverr,
    output logic        a2l_valid,
    input  logic        a2l_ready,
    output logic [87:0] a2l_data,
    input  logic        l2a_valid,
    output logic        l2a_accept,
    input  logic [56:0] l2a_data,
    output logic        rsp_mismatch
);
    typedef enum logic [1:0] {S_IDLE, S_SEND_REQ, S_WAIT_RSP, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_pwrite;
    logic        r_a2l_valid;
    logic [87:0] r_a2l_data;
    logic        r_pready;
    logic        r_pslverr;
    logic [31:0] r_prdata;
    logic        r_mismatch;

    logic        w_a2l_valid_nxt;
    logic [87:0] w_a2l_data_nxt;
    logic        w_pready_nxt;
    logic        w_pslverr_nxt;
    logic [31:0] w_prdata_nxt;
    logic        w_mismatch_nxt;

    logic        w_req_err;
    logic        w_req_go;
    logic [7:0]  w_exp_dt;
    logic        w_rsp_hit;
    logic        w_rsp_miss;
    logic        w_timeout;
    logic        w_stale_drop;
    logic [87:0] w_req_pkt;
    logic        w_unused;

    assign w_req_err  = apb_psel && !enable;
    assign w_req_go   = apb_psel && !apb_penable && enable;
    assign w_exp_dt   = r_pwrite ? APB_WRITE_RSP_DT : APB_READ_RSP_DT;
    assign w_rsp_hit  = (r_state == S_WAIT_RSP) && l2a_valid && (l2a_data[7:0] == w_exp_dt);
    assign w_rsp_miss = (r_state == S_WAIT_RSP) && l2a_valid && (l2a_data[7:0] != w_exp_dt);
    assign w_req_pkt  = apb_pwrite ? {apb_pwdata, apb_paddr, 16'd8, APB_WRITE_DT}
                                   : {32'd0, apb_paddr, 16'd4, APB_READ_DT};
    // Response word count carries no information the target needs.
    assign w_unused   = ^l2a_data[23:8];

`ifdef SLINK_APB_TGT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_stale;

    assign w_timeout    = (r_state == S_WAIT_RSP) && !w_rsp_hit &&
                          (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    // A timed-out request may still be answered later; swallow exactly one such answer.
    assign w_stale_drop = (r_state == S_IDLE) && r_stale && l2a_valid;

    always_ff @(posedge apb_clk) begin
        if (!apb_reset_n) begin
            r_to_cnt <= '0;
            r_stale  <= 1'b0;
        end else begin
            if ((r_state == S_WAIT_RSP) && !w_rsp_hit && !w_timeout)
                r_to_cnt <= r_to_cnt + CNT_W'(1);
            else
                r_to_cnt <= '0;
            if (w_timeout)
                r_stale <= 1'b1;
            else if (w_stale_drop)
                r_stale <= 1'b0;
        end
    end
`else
    logic [31:0] w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_stale_drop     = 1'b0;
    assign w_unused_timeout = TIMEOUT_CYCLES;
`endif

    assign l2a_accept = ((r_state == S_WAIT_RSP) && l2a_valid) || w_stale_drop;

    always_ff @(posedge apb_clk) begin
        if (!apb_reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_err)
                    w_state_nxt = S_DONE;
                else if (w_req_go)
                    w_state_nxt = S_SEND_REQ;
            end
            S_SEND_REQ: begin
                if (a2l_ready)
                    w_state_nxt = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (w_rsp_hit || w_timeout)
                    w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; completion fields are zero except in DONE.
    always_comb begin
        w_a2l_valid_nxt = 1'b0;
        w_a2l_data_nxt  = r_a2l_data;
        w_pready_nxt    = 1'b0;
        w_pslverr_nxt   = 1'b0;
        w_prdata_nxt    = 32'd0;
        w_mismatch_nxt  = r_mismatch | w_rsp_miss;
        case (r_state)
            S_IDLE: begin
                if (w_req_err) begin
                    w_pready_nxt  = 1'b1;
                    w_pslverr_nxt = 1'b1;
                end else if (w_req_go) begin
                    w_a2l_valid_nxt = 1'b1;
                    w_a2l_data_nxt  = w_req_pkt;
                end
            end
            S_SEND_REQ: begin
                w_a2l_valid_nxt = !a2l_ready;
            end
            S_WAIT_RSP: begin
                if (w_rsp_hit) begin
                    w_pready_nxt = 1'b1;
                    if (r_pwrite) begin
                        w_pslverr_nxt = l2a_data[24];
                    end else begin
                        w_pslverr_nxt = l2a_data[56];
                        w_prdata_nxt  = l2a_data[55:24];
                    end
                end else if (w_timeout) begin
                    w_pready_nxt  = 1'b1;
                    w_pslverr_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge apb_clk) begin
        if (!apb_reset_n) begin
            r_pwrite    <= 1'b0;
            r_a2l_valid <= 1'b0;
            r_a2l_data  <= 88'd0;
            r_pready    <= 1'b0;
            r_pslverr   <= 1'b0;
            r_prdata    <= 32'd0;
            r_mismatch  <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_req_go)
                r_pwrite <= apb_pwrite;
            r_a2l_valid <= w_a2l_valid_nxt;
            r_a2l_data  <= w_a2l_data_nxt;
            r_pready    <= w_pready_nxt;
            r_pslverr   <= w_pslverr_nxt;
            r_prdata    <= w_prdata_nxt;
            r_mismatch  <= w_mismatch_nxt;
        end
    end

    assign a2l_valid    = r_a2l_valid;
    assign a2l_data     = r_a2l_data;
    assign apb_pready   = r_pready;
    assign apb_pslverr  = r_pslverr;
    assign apb_prdata   = r_prdata;
    assign rsp_mismatch = r_mismatch;

endmodule

// File: tb/tb_slink_apb_tgt_pkt.sv
// Directed bench for slink_apb_tgt_pkt: transaction-level model (packet and completion
// queues) checked every cycle, plus hand-computed literal expectations.
module tb_slink_apb_tgt_pkt;
    logic        apb_clk = 1'b0;
    logic        apb_reset_n;
    logic        enable;
    logic        apb_psel;
    logic        apb_penable;
    logic        apb_pwrite;
    logic [31:0] apb_paddr;
    logic [31:0] apb_pwdata;
    logic [31:0] apb_prdata;
    logic        apb_pready;
    logic        apb_pslverr;
    logic        a2l_valid;
    logic        a2l_ready;
    logic [87:0] a2l_data;
    logic        l2a_valid;
    logic        l2a_accept;
    logic [56:0] l2a_data;
    logic        rsp_mismatch;

    always #5 apb_clk = ~apb_clk;

    slink_apb_tgt_pkt #(.TIMEOUT_CYCLES(16)) dut (
        .apb_clk      (apb_clk),
        .apb_reset_n  (apb_reset_n),
        .enable       (enable),
        .apb_psel     (apb_psel),
        .apb_penable  (apb_penable),
        .apb_pwrite   (apb_pwrite),
        .apb_paddr    (apb_paddr),
        .apb_pwdata   (apb_pwdata),
        .apb_prdata   (apb_prdata),
        .apb_pready   (apb_pready),
        .apb_pslverr  (apb_pslverr),
        .a2l_valid    (a2l_valid),
        .a2l_ready    (a2l_ready),
        .a2l_data     (a2l_data),
        .l2a_valid    (l2a_valid),
        .l2a_accept   (l2a_accept),
        .l2a_data     (l2a_data),
        .rsp_mismatch (rsp_mismatch)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [87:0] exp_pkt[$];
    logic [32:0] exp_cpl[$];
    logic        exp_mismatch = 1'b0;
    logic        chk_en = 1'b0;
    logic        prev_pready = 1'b0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check88(input string name, input logic [87:0] act, input logic [87:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Request packet built arithmetically: DT + WC*2^8 + addr*2^24 (+ wdata*2^56 for writes).
    function automatic logic [87:0] req_pkt(input logic w, input logic [31:0] addr,
                                            input logic [31:0] data);
        logic [87:0] p;
        p = w ? 88'h32 : 88'h30;
        p = p + ((w ? 88'd8 : 88'd4) << 8);
        p = p + (88'(addr) << 24);
        if (w)
            p = p + (88'(data) << 56);
        return p;
    endfunction

    function automatic logic [56:0] rsp_pkt(input logic [7:0] dt, input logic [32:0] payload);
        return 57'(dt) + (57'd4 << 8) + (57'(payload) << 24);
    endfunction

    // Expected completion {pslverr, prdata}: writes report payload bit 0 and no data.
    function automatic logic [32:0] cpl(input logic w, input logic [32:0] payload);
        if (w)
            return {payload[0], 32'd0};
        return payload;
    endfunction

    task automatic tick();
        @(posedge apb_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge apb_clk);
    endtask

    task automatic apb_setup(input logic w, input logic [31:0] a, input logic [31:0] d);
        apb_psel    = 1'b1;
        apb_penable = 1'b0;
        apb_pwrite  = w;
        apb_paddr   = a;
        apb_pwdata  = d;
        if (enable)
            exp_pkt.push_back(req_pkt(w, a, d));
    endtask

    task automatic apb_end();
        apb_psel    = 1'b0;
        apb_penable = 1'b0;
    endtask

    // Minimum-latency transaction: ready at T1, matching response at T2, pready at T3.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [32:0] pl);
        tick(); a2l_ready = 1'b1; apb_setup(w, a, d);
        tick(); apb_penable = 1'b1;
        tick(); l2a_valid = 1'b1; l2a_data = rsp_pkt(w ? 8'h33 : 8'h31, pl);
        exp_cpl.push_back(cpl(w, pl));
        tick(); l2a_valid = 1'b0;
        at_neg(); check1("txn_pready_T3", apb_pready, 1'b1);
        tick(); apb_end();
    endtask

    always @(negedge apb_clk) begin
        if (chk_en) begin
            if (a2l_valid) begin
                if (exp_pkt.size() == 0) begin
                    check1("a2l_unexpected", a2l_valid, 1'b0);
                end else begin
                    check88("a2l_pkt", a2l_data, exp_pkt[0]);
                    if (a2l_ready)
                        void'(exp_pkt.pop_front());
                end
            end
            if (apb_pready) begin
                if (exp_cpl.size() == 0) begin
                    check1("pready_unexpected", apb_pready, 1'b0);
                end else begin
                    check88("completion", 88'({apb_pslverr, apb_prdata}), 88'(exp_cpl[0]));
                    void'(exp_cpl.pop_front());
                end
            end
            check1("pready_single_cycle", prev_pready && apb_pready, 1'b0);
            check1("rsp_mismatch", rsp_mismatch, exp_mismatch);
            prev_pready = apb_pready;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation reached time limit, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        apb_reset_n = 1'b0;
        enable      = 1'b1;
        apb_psel    = 1'b0;
        apb_penable = 1'b0;
        apb_pwrite  = 1'b0;
        apb_paddr   = 32'd0;
        apb_pwdata  = 32'd0;
        a2l_ready   = 1'b0;
        l2a_valid   = 1'b0;
        l2a_data    = 57'd0;

        tick(); tick();
        at_neg();
        check1 ("rst_a2l_valid", a2l_valid, 1'b0);
        check88("rst_a2l_data", a2l_data, 88'd0);
        check1 ("rst_pready", apb_pready, 1'b0);
        check1 ("rst_pslverr", apb_pslverr, 1'b0);
        check32("rst_prdata", apb_prdata, 32'd0);
        check1 ("rst_mismatch", rsp_mismatch, 1'b0);
        check1 ("rst_accept", l2a_accept, 1'b0);
        tick(); apb_reset_n = 1'b1; chk_en = 1'b1;

        // Read, minimum latency
        tick(); a2l_ready = 1'b1; apb_setup(1'b0, 32'h1000_0040, 32'd0);
        at_neg(); check1("rd_T0_pready", apb_pready, 1'b0);
        tick(); apb_penable = 1'b1;
        at_neg();
        check1 ("rd_T1_valid", a2l_valid, 1'b1);
        check32("rd_dt", 32'(a2l_data[7:0]), 32'h30);
        check32("rd_wc", 32'(a2l_data[23:8]), 32'd4);
        check32("rd_addr", a2l_data[55:24], 32'h1000_0040);
        check32("rd_upper", a2l_data[87:56], 32'd0);
        tick(); l2a_valid = 1'b1; l2a_data = {1'b0, 32'hDEAD_BEEF, 16'd4, 8'h31};
        exp_cpl.push_back({1'b0, 32'hDEAD_BEEF});
        at_neg();
        check1("rd_T2_valid_low", a2l_valid, 1'b0);
        check1("rd_T2_accept", l2a_accept, 1'b1);
        check1("rd_T2_pready", apb_pready, 1'b0);
        tick(); l2a_valid = 1'b0;
        at_neg();
        check1 ("rd_T3_pready", apb_pready, 1'b1);
        check32("rd_prdata", apb_prdata, 32'hDEAD_BEEF);
        check1 ("rd_pslverr", apb_pslverr, 1'b0);
        tick(); apb_end();
        at_neg(); check1("rd_T4_pready", apb_pready, 1'b0);

        // Write with back-pressure; enable drops mid-transaction
        tick(); a2l_ready = 1'b0; apb_setup(1'b1, 32'h20, 32'h1234_5678);
        tick(); apb_penable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) enable = 1'b0;
            if (i == 5) a2l_ready = 1'b1;
            at_neg();
            check1 ("wr_valid_hold", a2l_valid, 1'b1);
            check88("wr_data_hold", a2l_data, 88'h12345678_00000020_0008_32);
            tick();
        end
        a2l_ready = 1'b0; enable = 1'b1;
        l2a_valid = 1'b1; l2a_data = {33'h1, 16'd1, 8'h33};
        exp_cpl.push_back({1'b1, 32'd0});
        at_neg();
        check1("wr_valid_low", a2l_valid, 1'b0);
        check1("wr_accept", l2a_accept, 1'b1);
        tick(); l2a_valid = 1'b0;
        at_neg();
        check1 ("wr_pready", apb_pready, 1'b1);
        check1 ("wr_pslverr", apb_pslverr, 1'b1);
        check32("wr_prdata", apb_prdata, 32'd0);
        tick(); apb_end();

        // Disabled block: immediate error, no packet
        tick(); enable = 1'b0; apb_setup(1'b0, 32'h100, 32'd0);
        exp_cpl.push_back({1'b1, 32'd0});
        at_neg(); check1("dis_T0_pready", apb_pready, 1'b0);
        tick(); apb_penable = 1'b1;
        at_neg();
        check1 ("dis_pready", apb_pready, 1'b1);
        check1 ("dis_pslverr", apb_pslverr, 1'b1);
        check32("dis_prdata", apb_prdata, 32'd0);
        check1 ("dis_no_valid", a2l_valid, 1'b0);
        tick(); apb_end(); enable = 1'b1;
        at_neg();
        check1("dis_pready_off", apb_pready, 1'b0);
        check1("dis_no_valid2", a2l_valid, 1'b0);

        // Wrong response type discarded, then the right one completes
        tick(); a2l_ready = 1'b1; apb_setup(1'b0, 32'h44, 32'd0);
        tick(); apb_penable = 1'b1;
        tick(); l2a_valid = 1'b1; l2a_data = rsp_pkt(8'h33, 33'h0_1111_2222);
        at_neg();
        check1("mm_accept1", l2a_accept, 1'b1);
        check1("mm_flag_pre", rsp_mismatch, 1'b0);
        tick(); exp_mismatch = 1'b1; l2a_data = rsp_pkt(8'h31, 33'h0_CAFE_F00D);
        exp_cpl.push_back(cpl(1'b0, 33'h0_CAFE_F00D));
        at_neg();
        check1("mm_flag", rsp_mismatch, 1'b1);
        check1("mm_accept2", l2a_accept, 1'b1);
        check1("mm_no_pready", apb_pready, 1'b0);
        tick(); l2a_valid = 1'b0;
        at_neg();
        check1 ("mm_pready", apb_pready, 1'b1);
        check32("mm_prdata", apb_prdata, 32'hCAFE_F00D);
        tick(); apb_end();

        // Further patterns through the model
        txn(1'b0, 32'hFFFF_FFFC, 32'd0, 33'h1_0000_55AA);
        txn(1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 33'h0);
        txn(1'b1, 32'hA000_0000, 32'h0F0F_0F0F, 33'h1_FFFF_FFFF);
        txn(1'b0, 32'h0000_0000, 32'd0, 33'h0_8000_0001);

`ifdef SLINK_APB_TGT_TIMEOUT_EN
        tick(); a2l_ready = 1'b1; apb_setup(1'b0, 32'h300, 32'd0);
        tick(); apb_penable = 1'b1;
        exp_cpl.push_back({1'b1, 32'd0});
        for (int i = 0; i < 16; i++) begin
            tick(); at_neg(); check1("to_wait_no_pready", apb_pready, 1'b0);
        end
        tick(); at_neg();
        check1 ("to_pready", apb_pready, 1'b1);
        check1 ("to_pslverr", apb_pslverr, 1'b1);
        check32("to_prdata", apb_prdata, 32'd0);
        tick(); apb_end(); l2a_valid = 1'b1; l2a_data = rsp_pkt(8'h31, 33'h0_0BAD_F00D);
        at_neg(); check1("stale_accept", l2a_accept, 1'b1);
        tick(); at_neg();
        check1("stale_once", l2a_accept, 1'b0);
        check1("stale_no_pready", apb_pready, 1'b0);
        tick(); l2a_valid = 1'b0;
`else
        tick(); a2l_ready = 1'b1; apb_setup(1'b0, 32'h300, 32'd0);
        tick(); apb_penable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(); at_neg(); check1("nowait_no_pready", apb_pready, 1'b0);
        end
        tick(); l2a_valid = 1'b1; l2a_data = rsp_pkt(8'h31, 33'h0_0BAD_F00D);
        exp_cpl.push_back(cpl(1'b0, 33'h0_0BAD_F00D));
        tick(); l2a_valid = 1'b0;
        at_neg(); check1("nowait_pready", apb_pready, 1'b1);
        tick(); apb_end();
`endif

        // Reset while waiting for a response
        tick(); a2l_ready = 1'b1; apb_setup(1'b1, 32'h80, 32'hA5A5_A5A5);
        tick(); apb_penable = 1'b1;
        tick();
        at_neg(); check1("rw_wait_no_pready", apb_pready, 1'b0);
        tick(); apb_reset_n = 1'b0; apb_end();
        l2a_valid = 1'b1; l2a_data = rsp_pkt(8'h33, 33'h0);
        tick(); exp_mismatch = 1'b0;
        at_neg();
        check1 ("rw_a2l_valid", a2l_valid, 1'b0);
        check88("rw_a2l_data", a2l_data, 88'd0);
        check1 ("rw_pready", apb_pready, 1'b0);
        check1 ("rw_pslverr", apb_pslverr, 1'b0);
        check32("rw_prdata", apb_prdata, 32'd0);
        check1 ("rw_mismatch", rsp_mismatch, 1'b0);
        check1 ("rw_accept", l2a_accept, 1'b0);
        tick(); apb_reset_n = 1'b1;
        at_neg(); check1("rw_late_rsp_ignored", l2a_accept, 1'b0);
        tick();
        at_neg();
        check1("rw_late_rsp_ignored2", l2a_accept, 1'b0);
        check1("rw_no_pready", apb_pready, 1'b0);
        tick(); l2a_valid = 1'b0;
        tick();

        at_neg();
        check32("pkt_queue_drained", 32'(exp_pkt.size()), 32'd0);
        check32("cpl_queue_drained", 32'(exp_cpl.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
